sdram_req_sched: RTL and testbench

//  Scheduler in front of SDRAM_TOP. Shares the single SDRAM command port between a burst-write client
//  (image FIFO side), a burst-read client and the periodic auto-refresh. Issues one request at a time,

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_ref_timer.sv | 48 ++++
 rtl/sdram_req_sched.sv | 127 ++++++++++++
 tb/tb_sdram_req_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM front end.
// Holds the state encoding and default sizing, and is used by SDRAM_TOP as well.
package sdram_pkg;

    localparam int DEF_ADDR_W     = 20;
    localparam int DEF_BURST_LEN  = 256;
    localparam int DEF_REF_CYCLES = 780;   // 15.6 us at 50 MHz

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REF  = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RD   = 2'd3;

    // Encoding of the most recently served burst client.
    localparam logic LAST_RD = 1'b0;
    localparam logic LAST_WR = 1'b1;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises ref_pend every REF_CYCLES enabled cycles
// and flags a sticky overrun when an interval expires with a refresh still owed.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = DEF_REF_CYCLES
) (
    input  logic S_CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic ref_pend,
    output logic ref_overrun
);

    localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_CYCLES - 1);

    logic [CNT_W-1:0] timer;
    logic             expire;

    assign expire = en && (timer == CNT_LAST);

    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            timer       <= '0;
            ref_pend    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (expire) begin
                timer <= '0;
            end else if (en) begin
                timer <= timer + 1'b1;
            end

            // A new expiry beats a same-cycle clear so the fresh request is not lost.
            if (expire) begin
                ref_pend <= 1'b1;
                if (ref_pend) begin
                    ref_overrun <= 1'b1;
                end
            end else if (clr) begin
                ref_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_req_sched.sv
// Arbitrates the single SDRAM command port between refresh, a burst writer and a
// burst reader, one request at a time, with wrapping per-client burst pointers.
module sdram_req_sched
    import sdram_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                BURST_LEN  = DEF_BURST_LEN,
    parameter logic [ADDR_W-1:0] ADDR_LAST  = 'hFFF00,
    parameter int                REF_CYCLES = DEF_REF_CYCLES
) (
    input  logic              S_CLK,
    input  logic              RST,
    input  logic              init_done,
    input  logic              wr_pending,
    input  logic              rd_pending,
    output logic              write_req,
    input  logic              write_ack,
    output logic              read_req,
    input  logic              read_ack,
    output logic              ref_req,
    input  logic              ref_ack,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              wr_wrap,
    output logic              rd_wrap,
    output logic              ref_overrun
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);

    logic [1:0]        state;
    logic              last;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              ref_pend;
    logic              ref_done;

    assign ref_done = (state == ST_REF) && ref_ack;

    sdram_ref_timer #(
        .REF_CYCLES (REF_CYCLES)
    ) u_ref_timer (
        .S_CLK       (S_CLK),
        .RST         (RST),
        .en          (init_done),
        .clr         (ref_done),
        .ref_pend    (ref_pend),
        .ref_overrun (ref_overrun)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values of state, pointers and ref_pend.
    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            last       <= LAST_RD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            write_req  <= 1'b0;
            read_req   <= 1'b0;
            ref_req    <= 1'b0;
            sdram_addr <= '0;
            wr_wrap    <= 1'b0;
            rd_wrap    <= 1'b0;
        end else begin
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Refresh first, then round-robin between the burst clients.
                    if (init_done) begin
                        if (ref_pend) begin
                            state   <= ST_REF;
                            ref_req <= 1'b1;
                        end else if (wr_pending && (!rd_pending || last == LAST_RD)) begin
                            state      <= ST_WR;
                            write_req  <= 1'b1;
                            sdram_addr <= wr_ptr;
                        end else if (rd_pending) begin
                            state      <= ST_RD;
                            read_req   <= 1'b1;
                            sdram_addr <= rd_ptr;
                        end
                    end
                end

                ST_REF: begin
                    if (ref_ack) begin
                        ref_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                ST_WR: begin
                    if (write_ack) begin
                        write_req <= 1'b0;
                        last      <= LAST_WR;
                        state     <= ST_IDLE;
                        if (wr_ptr == ADDR_LAST) begin
                            wr_ptr  <= '0;
                            wr_wrap <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + STEP;
                        end
                    end
                end

                ST_RD: begin
                    if (read_ack) begin
                        read_req <= 1'b0;
                        last     <= LAST_RD;
                        state    <= ST_IDLE;
                        if (rd_ptr == ADDR_LAST) begin
                            rd_ptr  <= '0;
                            rd_wrap <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + STEP;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_sched.sv
// Randomised bench for sdram_req_sched: an acking BFM drives the SDRAM side and a
// transaction-level model (burst counts, enabled-cycle count) predicts every output.
module tb_sdram_req_sched;

    localparam int          BL    = 256;
    localparam int          REFC  = 50;
    localparam logic [19:0] ALAST = 20'h00200;
    localparam int          SLOTS = int'(ALAST) / BL + 1;

    logic        S_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        init_done = 1'b0;
    logic        wr_pending = 1'b0;
    logic        rd_pending = 1'b0;
    logic        write_ack = 1'b0;
    logic        read_ack = 1'b0;
    logic        ref_ack = 1'b0;
    logic        write_req, read_req, ref_req;
    logic [19:0] sdram_addr;
    logic        wr_wrap, rd_wrap, ref_overrun;

    sdram_req_sched #(
        .ADDR_W     (20),
        .BURST_LEN  (BL),
        .ADDR_LAST  (ALAST),
        .REF_CYCLES (REFC)
    ) dut (
        .S_CLK       (S_CLK),
        .RST         (RST),
        .init_done   (init_done),
        .wr_pending  (wr_pending),
        .rd_pending  (rd_pending),
        .write_req   (write_req),
        .write_ack   (write_ack),
        .read_req    (read_req),
        .read_ack    (read_ack),
        .ref_req     (ref_req),
        .ref_ack     (ref_ack),
        .sdram_addr  (sdram_addr),
        .wr_wrap     (wr_wrap),
        .rd_wrap     (rd_wrap),
        .ref_overrun (ref_overrun)
    );

    always #5 S_CLK = ~S_CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: which transfer is in flight (0 none, 1 refresh, 2 write, 3 read),
    // how many bursts each client has completed, and how many enabled cycles elapsed.
    int          m_kind;
    int          m_wr_n, m_rd_n;
    bit          m_last_wr;
    bit          m_pend, m_ovr;
    int          m_en;
    logic [19:0] m_addr;
    bit          m_wwrap, m_rwrap;
    int          m_wwrap_n, m_rwrap_n;
    int          obs_wwrap_n, obs_rwrap_n;
    int          bfm_cnt, bfm_delay;

    task automatic model_reset();
        m_kind = 0; m_wr_n = 0; m_rd_n = 0; m_last_wr = 1'b0;
        m_pend = 1'b0; m_ovr = 1'b0; m_en = 0; m_addr = '0;
        m_wwrap = 1'b0; m_rwrap = 1'b0;
    endtask

    task automatic model_step();
        bit expire = 1'b0;
        bit served_ref = 1'b0;
        m_wwrap = 1'b0;
        m_rwrap = 1'b0;
        if (init_done) begin
            m_en++;
            expire = (m_en % REFC) == 0;
        end
        case (m_kind)
            0: if (init_done) begin
                if (m_pend)                      m_kind = 1;
                else if (wr_pending && rd_pending) m_kind = m_last_wr ? 3 : 2;
                else if (wr_pending)             m_kind = 2;
                else if (rd_pending)             m_kind = 3;
                if (m_kind == 2) m_addr = 20'((m_wr_n % SLOTS) * BL);
                if (m_kind == 3) m_addr = 20'((m_rd_n % SLOTS) * BL);
            end
            1: if (ref_ack) begin
                m_kind = 0;
                served_ref = 1'b1;
            end
            2: if (write_ack) begin
                m_wr_n++;
                m_wwrap = (m_wr_n % SLOTS) == 0;
                if (m_wwrap) m_wwrap_n++;
                m_last_wr = 1'b1;
                m_kind = 0;
            end
            3: if (read_ack) begin
                m_rd_n++;
                m_rwrap = (m_rd_n % SLOTS) == 0;
                if (m_rwrap) m_rwrap_n++;
                m_last_wr = 1'b0;
                m_kind = 0;
            end
            default: m_kind = 0;
        endcase
        if (expire) begin
            if (m_pend) m_ovr = 1'b1;
            m_pend = 1'b1;
        end else if (served_ref) begin
            m_pend = 1'b0;
        end
    endtask

    // One clock: drive stimulus and BFM acks, advance the model, compare at the falling edge.
    task automatic cycle(input int p_wr, input int p_rd, input int dmin, input int dmax,
                         input int init_mode, input bit spur);
        bit          acked = 1'b0;
        logic [5:0]  got_ctl, exp_ctl;
        case (init_mode)
            0: init_done = 1'b0;
            1: init_done = 1'b1;
            default: if ($urandom_range(99) < 2) init_done = ~init_done;
        endcase
        wr_pending = $urandom_range(99) < p_wr;
        rd_pending = $urandom_range(99) < p_rd;
        write_ack = 1'b0;
        read_ack  = 1'b0;
        ref_ack   = 1'b0;
        if (write_req || read_req || ref_req) begin
            if (bfm_cnt == 0)
                bfm_delay = ref_req ? int'($urandom_range(1, 8)) : int'($urandom_range(dmin, dmax));
            bfm_cnt++;
            if (bfm_cnt >= bfm_delay) begin
                write_ack = write_req;
                read_ack  = read_req;
                ref_ack   = ref_req;
                bfm_cnt   = 0;
                acked     = 1'b1;
            end
        end else begin
            bfm_cnt = 0;
        end
        if (spur && !acked && $urandom_range(15) == 0) begin
            case ($urandom_range(2))
                0: if (!write_req) write_ack = 1'b1;
                1: if (!read_req)  read_ack  = 1'b1;
                default: if (!ref_req) ref_ack = 1'b1;
            endcase
        end
        model_step();
        @(negedge S_CLK);
        if (wr_wrap) obs_wwrap_n++;
        if (rd_wrap) obs_rwrap_n++;
        got_ctl = {ref_req, write_req, read_req, wr_wrap, rd_wrap, ref_overrun};
        exp_ctl = {m_kind == 1, m_kind == 2, m_kind == 3, m_wwrap, m_rwrap, m_ovr};
        check("ctl{ref,wr,rd,wwrap,rwrap,ovr}", 32'(got_ctl), 32'(exp_ctl));
        if (m_kind >= 2) check("sdram_addr", 32'(sdram_addr), 32'(m_addr));
    endtask

    task automatic run(input int n, input int p_wr, input int p_rd, input int dmin,
                       input int dmax, input int init_mode, input bit spur);
        for (int i = 0; i < n; i++) cycle(p_wr, p_rd, dmin, dmax, init_mode, spur);
    endtask

    task automatic reset_mid_burst();
        for (int i = 0; i < 2000 && m_kind != 2; i++) cycle(100, 0, 20, 30, 1, 1'b0);
        if (m_kind != 2) check("reach_write_burst", 32'(m_kind), 32'd2);
        RST = 1'b1;
        #1;
        check("rst_ctl", 32'({ref_req, write_req, read_req, wr_wrap, rd_wrap, ref_overrun}), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        model_reset();
        bfm_cnt = 0;
        write_ack = 1'b0; read_ack = 1'b0; ref_ack = 1'b0;
        wr_pending = 1'b0; rd_pending = 1'b0;
        @(negedge S_CLK);
        @(negedge S_CLK);
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        m_wwrap_n = 0; m_rwrap_n = 0; obs_wwrap_n = 0; obs_rwrap_n = 0;
        bfm_cnt = 0; bfm_delay = 1;
        repeat (3) @(negedge S_CLK);
        check("reset_ctl", 32'({ref_req, write_req, read_req, wr_wrap, rd_wrap, ref_overrun}), 32'd0);
        check("reset_addr", 32'(sdram_addr), 32'd0);
        RST = 1'b0;

        run(1000, 100, 0, 3, 6, 0, 1'b0);     // held off until init completes
        run(40, 100, 0, 3, 6, 1, 1'b0);       // first write at address 0
        run(300, 100, 100, 2, 8, 1, 1'b0);    // alternating grants with refresh interleaved
        run(2000, 60, 60, 1, 20, 2, 1'b1);    // random traffic, init drops, spurious acks
        reset_mid_burst();
        run(40, 100, 0, 3, 6, 1, 1'b0);       // restart from address 0
        run(400, 100, 100, 110, 130, 1, 1'b0); // long bursts force refresh overrun
        run(800, 70, 70, 1, 30, 2, 1'b1);

        check("wr_wrap_count", 32'(obs_wwrap_n), 32'(m_wwrap_n));
        check("rd_wrap_count", 32'(obs_rwrap_n), 32'(m_rwrap_n));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
